// File: rtl/fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// fetch_arbiter_if : bundle of core-side requests, shared-memory port and results
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

interface fetch_arbiter_if;
  logic [`DATAWIDTH-1:0] pc;
  logic                  if_req;
  logic                  flush;
  logic                  d_req;
  logic                  d_we;
  logic [`DATAWIDTH-1:0] d_addr;
  logic [`DATAWIDTH-1:0] d_wdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [`DATAWIDTH-1:0] mem_addr;
  logic [`DATAWIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [`DATAWIDTH-1:0] mem_rdata;
  logic [`DATAWIDTH-1:0] instr;
  logic                  instr_valid;
  logic [`DATAWIDTH-1:0] d_rdata;
  logic                  d_done;
  logic                  pcEn;

  modport master (
    input  pc, if_req, flush, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, instr, instr_valid, d_rdata, d_done, pcEn
  );

  modport slave (
    output pc, if_req, flush, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, instr, instr_valid, d_rdata, d_done, pcEn
  );
endinterface

`default_nettype wire

// File: rtl/fetch_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_arbiter : shares one single-port memory between instruction fetch and data access
// Optional macro ARB_FAIR_EN selects round-robin arbitration. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_arbiter (
  input  wire logic       clk,
  input  wire logic       rst,
  fetch_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IF   = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  flush_seen_q, flush_seen_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [`DATAWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [`DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [`DATAWIDTH-1:0] instr_q, instr_d;
  logic [`DATAWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  d_done_q, d_done_d;
  logic                  pcEn_q, pcEn_d;
  logic                  grant_data;
  logic                  grant_fetch;
  logic                  can_grant;

  // A flush seen in S_IDLE only advances pc; no request is granted that cycle.
  assign can_grant = (state_q == S_IDLE) && !bus.flush;

`ifdef ARB_FAIR_EN
  logic last_data_q, last_data_d;

  always_comb begin
    last_data_d = last_data_q;
    if (can_grant && (bus.d_req || bus.if_req)) last_data_d = grant_data;
  end

  always_ff @(posedge clk) begin
    if (rst) last_data_q <= 1'b0;
    else     last_data_q <= last_data_d;
  end

  assign grant_data = bus.d_req && (!bus.if_req || !last_data_q);
`else
  assign grant_data = bus.d_req;
`endif

  assign grant_fetch = bus.if_req && !grant_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      flush_seen_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_q       <= '0;
      d_rdata_q     <= '0;
      instr_valid_q <= 1'b0;
      d_done_q      <= 1'b0;
      pcEn_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_seen_q  <= flush_seen_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_q       <= instr_d;
      d_rdata_q     <= d_rdata_d;
      instr_valid_q <= instr_valid_d;
      d_done_q      <= d_done_d;
      pcEn_q        <= pcEn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_seen_d = flush_seen_q;
    case (state_q)
      S_IDLE: begin
        flush_seen_d = 1'b0;
        if (can_grant && grant_data)       state_d = S_DATA;
        else if (can_grant && grant_fetch) state_d = S_IF;
      end
      S_IF: begin
        if (bus.flush)     flush_seen_d = 1'b1;
        if (bus.mem_ready) state_d = S_DONE;
      end
      S_DATA: begin
        if (bus.mem_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completion pulses are set on entry to S_DONE so they appear while in S_DONE.
  always_comb begin
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instr_d       = instr_q;
    d_rdata_d     = d_rdata_q;
    instr_valid_d = 1'b0;
    d_done_d      = 1'b0;
    pcEn_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          pcEn_d = 1'b1;
        end else if (grant_data) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else if (grant_fetch) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.pc;
        end
      end
      S_IF: begin
        if (bus.mem_ready) begin
          mem_req_d     = 1'b0;
          instr_d       = bus.mem_rdata;
          instr_valid_d = !(bus.flush || flush_seen_q);
          pcEn_d        = !(bus.flush || flush_seen_q);
        end
      end
      S_DATA: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) d_rdata_d = bus.mem_rdata;
          d_done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.instr       = instr_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.d_done      = d_done_q;
  assign bus.pcEn        = pcEn_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fetch_arbiter : scoreboard bench with a wait-state memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_arbiter;

  typedef struct {
    int          kind;   // 0 fetch, 1 data, 2 flush-only pc advance
    logic [15:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } mem_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   mem_wait;

  resp_t exp_q[$];
  mem_t  exp_mem[$];

  fetch_arbiter_if bus();

  fetch_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: checks each new request, then answers after mem_wait cycles.
  initial begin : mem_model
    bit   in_txn;
    int   wcnt;
    mem_t cur;
    in_txn        = 1'b0;
    wcnt          = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      if (bus.mem_req === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt   = 0;
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: addr=%h we=%b, required no request", bus.mem_addr, bus.mem_we);
            cur.rdata = 16'h0000;
          end else begin
            cur = exp_mem.pop_front();
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
            chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, cur.addr});
            if (cur.we) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, cur.wdata});
          end
        end
        if (wcnt == mem_wait) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = cur.rdata;
          in_txn        = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  // Monitor: every completion or pc-advance pulse must match the next expected response.
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1 || bus.d_done === 1'b1 || bus.pcEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: instr_valid=%b d_done=%b pcEn=%b, required no pulse",
                   bus.instr_valid, bus.d_done, bus.pcEn);
        end else begin
          r = exp_q.pop_front();
          chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, r.kind == 0});
          chk("d_done", {31'd0, bus.d_done}, {31'd0, r.kind == 1});
          chk("pcEn", {31'd0, bus.pcEn}, {31'd0, r.kind != 1});
          if (r.kind == 0) chk("instr", {16'd0, bus.instr}, {16'd0, r.data});
          if (r.kind == 1) chk("d_rdata", {16'd0, bus.d_rdata}, {16'd0, r.data});
          if (r.cyc >= 0) chk("pulse_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata;
    exp_mem.push_back(m);
  endtask

  task automatic push_resp(input int kind, input logic [15:0] data, input int at_cyc);
    resp_t r;
    r.kind = kind; r.data = data; r.cyc = at_cyc;
    exp_q.push_back(r);
  endtask

  // Single transaction from idle; request dropped right after the grant edge.
  task automatic issue(input bit is_data, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata,
                       input logic [15:0] exp_d, input int wt);
    mem_wait = wt;
    push_mem(is_data ? we : 1'b0, addr, wdata, rdata);
    push_resp(is_data ? 1 : 0, exp_d, cyc + wt + 2);
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.pc = addr;
    end
    @(negedge clk);
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    repeat (wt + 4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    chk({tag, "_instr"}, {16'd0, bus.instr}, 32'd0);
    chk({tag, "_d_rdata"}, {16'd0, bus.d_rdata}, 32'd0);
    chk({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_d_done"}, {31'd0, bus.d_done}, 32'd0);
    chk({tag, "_pcEn"}, {31'd0, bus.pcEn}, 32'd0);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    mem_wait    = 0;
    rst         = 1'b1;
    bus.pc      = 16'h0000;
    bus.if_req  = 1'b0;
    bus.flush   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Fetch with two wait states: pulse four cycles after the grant cycle.
    issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 16'hA5C3, 2);
    // Load, then a store which must leave d_rdata holding the loaded value.
    issue(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234, 16'h1234, 1);
    issue(1'b1, 1'b1, 16'h0210, 16'h5A5A, 16'h0000, 16'h1234, 1);

    // Flush while idle: one pcEn pulse next cycle, no memory access.
    push_resp(2, 16'h0000, cyc + 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);

    // Flush during the fetch wait: access still happens, no pulse.
    mem_wait = 3;
    push_mem(1'b0, 16'h0040, 16'h0000, 16'h0BAD);
    bus.if_req = 1'b1;
    bus.pc     = 16'h0040;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.flush  = 1'b1;
    @(negedge clk);
    bus.flush  = 1'b0;
    repeat (8) @(negedge clk);

    // Next fetch after a flush behaves normally.
    issue(1'b0, 1'b0, 16'h0012, 16'h0000, 16'h7E01, 16'h7E01, 0);

    // Contention from a fresh reset so the fairness pointer starts at fetch-last.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_wait = 0;
    for (int i = 0; i < 4; i++) begin
      bit dgrant;
`ifdef ARB_FAIR_EN
      dgrant = (i % 2) == 0;
`else
      dgrant = 1'b1;
`endif
      if (dgrant) begin
        push_mem(1'b0, 16'h0400, 16'h0000, 16'hC000 + 16'(i));
        push_resp(1, 16'hC000 + 16'(i), cyc + 3 * i + 2);
      end else begin
        push_mem(1'b0, 16'h0020, 16'h0000, 16'hC000 + 16'(i));
        push_resp(0, 16'hC000 + 16'(i), cyc + 3 * i + 2);
      end
    end
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0400;
    bus.if_req = 1'b1;
    bus.pc     = 16'h0020;
    repeat (10) @(negedge clk);
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    repeat (4) @(negedge clk);

    // Store aborted by reset while in S_DATA: no d_done, outputs back to reset values.
    mem_wait = 5;
    push_mem(1'b1, 16'h0300, 16'hBEEF, 16'h0000);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0300;
    bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    bus.d_req = 1'b0;
    chk("store_mem_req_active", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    chk("pending_responses", exp_q.size(), 32'd0);
    chk("pending_mem_requests", exp_mem.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
